p2s_lane_scheduler: RTL
=======================

Name: p2s_lane_scheduler

Overview:
- Byte-slot scheduler ahead of the two-lane parallel-to-serial stage.
- Shares both serializer lanes between four show-ahead byte FIFOs using round-robin grants.
- Sequences link bring-up with comma training.
- Holds each lane's byte and valid stable for a full 8-cycle serialization slot on clk_8f.

Parameters:
- COMMA, 8'hBC, byte driven on idle or invalid lanes and during training.
- INIT_SLOTS, 4, number of byte slots spent in INIT before ACTIVE (legal range 1..15).

Ports:
- clk_8f  input  1  bit-rate clock; the only clock.
- reset_L  input  1  asynchronous, active-low reset.
- enable  input  1  link enable; level-sensitive.
- req_valid  input  4  requester i FIFO non-empty.
- req_data  input  32  show-ahead head bytes; requester i is [8i+7:8i].
- req_pop  output  4  one-cycle pop strobe per requester.
- data_out0  output  8  lane 0 byte to serializer.
- valid_out0  output  1  lane 0 byte valid.
- data_out1  output  8  lane 1 byte to serializer.
- valid_out1  output  1  lane 1 byte valid.
- state  output  2  00 IDLE, 01 INIT, 10 ACTIVE.
- slot_start  output  1  high during the first cycle of each byte slot (bit_cnt==0).

Behaviour:
Reset:
- reset_L low asynchronously forces: bit_cnt=0, state=IDLE, rr_ptr=0, init_cnt=0.
- Outputs: data_out0/1=COMMA, valid_out0/1=0, req_pop=0.
- Reset mid-slot discards the current bytes; already-popped bytes are lost by design.

Slot timing:
- 3-bit bit_cnt increments every clk_8f edge and wraps 7->0; it runs in every state.
- Boundary cycle = cycle with bit_cnt==7.
- All state, lane and pointer updates occur only at the clk_8f edge that ends a boundary cycle.
- Lane outputs are registered and change only at that edge.

State machine (evaluated at boundary edges only):
- IDLE: lanes COMMA/valid 0. enable=1 -> INIT with init_cnt=0.
- INIT: lanes COMMA/valid 0; init_cnt increments each slot. When init_cnt==INIT_SLOTS-1 -> ACTIVE. enable=0 -> IDLE immediately.
- ACTIVE: arbitration each slot (below). enable=0 -> IDLE; the slot already loaded completes its 8 cycles, no new pops.

Arbitration (ACTIVE, boundary cycle):
- Search req_valid starting at rr_ptr, ascending modulo 4.
- First requester found -> lane 0; second distinct requester -> lane 1.
- req_pop is combinational: high during the boundary cycle for granted requesters only, so at most 2 bits set.
- At the edge: data_outN <= granted req_data byte, valid_outN <= 1. A lane with no grant gets COMMA / valid 0.
- rr_ptr <= (last granted index + 1) mod 4. If there are no grants, rr_ptr holds.
- A single requester is never granted both lanes in one slot.
- req_valid changes outside the boundary cycle have no effect.

Boundary conditions:
- All req_valid=0: both lanes COMMA/valid 0 and no pops.
- Exactly one valid: that requester goes to lane 0, lane 1 is idle.
- enable toggled within one slot: only the value in the boundary cycle matters.

Optional Feature:
- Macro: P2S_LANE_STATS_EN.
- When defined, adds two outputs: byte_cnt0 [15:0] and byte_cnt1 [15:0].
  - Each counts slots loaded with valid=1 on its lane.
  - Counters saturate at 16'hFFFF and are cleared by reset_L.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset release with enable=0 for 24 cycles -> state=00, lanes 8'hBC/valid 0, req_pop=0, slot_start pulses every 8 cycles.
2. enable=1 at cycle 0 -> INIT for exactly 4 slots of COMMA, then state=10 at the 5th boundary edge.
3. ACTIVE, all four valid with heads 8'h11,22,33,44 -> slot1 lanes 11/22 (pops 0011), slot2 33/44 (pops 1100), slot3 11/22; each byte is held exactly 8 cycles.
4. ACTIVE, only req_valid[2]=1 (data 8'hA5) -> lane0=A5 valid 1, lane1=BC valid 0, req_pop=0100, rr_ptr=3.
5. enable dropped mid-slot in ACTIVE -> current bytes stay 8 cycles, no pop at the next boundary, state=00, then lanes COMMA.
6. reset_L pulsed low at bit_cnt=3 in ACTIVE -> outputs return to COMMA/valid 0 immediately without a clock edge; byte_cnt0/1=0 when P2S_LANE_STATS_EN is defined.

Source files
------------

// File: rtl/p2s_lane_scheduler.sv
// Round-robin byte-slot scheduler feeding two serializer lanes, with comma-training bring-up.
// Optional per-lane loaded-byte counters are built when P2S_LANE_STATS_EN is defined.
module p2s_lane_scheduler #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned INIT_SLOTS = 4
) (
  input  logic        clk_8f,
  input  logic        reset_L,
  input  logic        enable,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_pop,
  output logic [7:0]  data_out0,
  output logic        valid_out0,
  output logic [7:0]  data_out1,
  output logic        valid_out1,
  output logic [1:0]  state,
`ifdef P2S_LANE_STATS_EN
  output logic [15:0] byte_cnt0,
  output logic [15:0] byte_cnt1,
`endif
  output logic        slot_start
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StInit   = 2'b01,
    StActive = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  init_cnt_q, init_cnt_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]  data0_q, data0_d, data1_q, data1_d;
  logic        valid0_q, valid0_d, valid1_q, valid1_d;

  logic        boundary, grant_en;
  logic        found0, found1;
  logic [1:0]  g0, g1, idx;

  assign boundary = (bit_cnt_q == 3'd7);
  assign grant_en = boundary && (state_q == StActive) && enable;

  // First and second valid requesters, searching upward from rr_ptr.
  always_comb begin
    found0 = 1'b0;
    found1 = 1'b0;
    g0     = '0;
    g1     = '0;
    idx    = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (req_valid[idx]) begin
        if (!found0) begin
          found0 = 1'b1;
          g0     = idx;
        end else if (!found1) begin
          found1 = 1'b1;
          g1     = idx;
        end
      end
    end
  end

  always_comb begin
    req_pop = '0;
    if (grant_en) begin
      req_pop = (4'(found0) << g0) | (4'(found1) << g1);
    end
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q + 3'd1;
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    data0_d    = data0_q;
    valid0_d   = valid0_q;
    data1_d    = data1_q;
    valid1_d   = valid1_q;
    if (boundary) begin
      data0_d  = COMMA;
      valid0_d = 1'b0;
      data1_d  = COMMA;
      valid1_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_d    = StInit;
            init_cnt_d = '0;
          end
        end
        StInit: begin
          if (!enable) begin
            state_d = StIdle;
          end else if (init_cnt_q == 4'(INIT_SLOTS - 1)) begin
            state_d = StActive;
          end else begin
            init_cnt_d = init_cnt_q + 4'd1;
          end
        end
        StActive: begin
          if (!enable) begin
            state_d = StIdle;
          end else begin
            if (found0) begin
              data0_d  = req_data[{g0, 3'b000} +: 8];
              valid0_d = 1'b1;
              rr_ptr_d = g0 + 2'd1;
            end
            if (found1) begin
              data1_d  = req_data[{g1, 3'b000} +: 8];
              valid1_d = 1'b1;
              rr_ptr_d = g1 + 2'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      init_cnt_q <= '0;
      rr_ptr_q   <= '0;
      data0_q    <= COMMA;
      valid0_q   <= 1'b0;
      data1_q    <= COMMA;
      valid1_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      init_cnt_q <= init_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      data0_q    <= data0_d;
      valid0_q   <= valid0_d;
      data1_q    <= data1_d;
      valid1_q   <= valid1_d;
    end
  end

`ifdef P2S_LANE_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Count only the edge that loads a slot, saturating at all-ones.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (boundary && valid0_d && (cnt0_q != 16'hFFFF)) cnt0_d = cnt0_q + 16'd1;
    if (boundary && valid1_d && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign byte_cnt0 = cnt0_q;
  assign byte_cnt1 = cnt1_q;
`endif

  assign data_out0  = data0_q;
  assign valid_out0 = valid0_q;
  assign data_out1  = data1_q;
  assign valid_out1 = valid1_q;
  assign state      = state_q;
  assign slot_start = (bit_cnt_q == 3'd0);

endmodule
